// File: rtl/score_seg_driver.sv
// ---------------------------------------------------------------------------
// score_seg_driver
//
// Converts the game score (or the best score while dead) to BCD with a
// sequential double-dabble converter and drives a 4-digit, common-anode,
// multiplexed seven-segment display. It also tracks the best score, which is
// captured on each rising edge of the death flag.
//
// Ports
//   clk        in   system clock, rising edge
//   clrn       in   asynchronous active-low reset
//   state[1:0] in   game state: 00 idle, 01 playing, 10 dead, 11 idle
//   score[7:0] in   current binary score
//   isDead     in   death flag (level)
//   AN[3:0]    out  digit enables, active-low, AN[0] = rightmost digit
//   SEGMENT[7:0] out segments {dp,g,f,e,d,c,b,a}, active-low
//   best[7:0]  out  highest score captured since reset
//   bcd_valid  out  displayed digits match the current source value
//
// Conversion FSM: CONV_IDLE -> CONV_SHIFT (8 cycles) -> CONV_DONE -> CONV_IDLE.
// The load happens on the IDLE->SHIFT edge, so bcd_valid is low for 9 cycles.
// ---------------------------------------------------------------------------
module score_seg_driver #(
    parameter int SCAN_BITS = 17
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [1:0] state,
    input  logic [7:0] score,
    input  logic       isDead,
    output logic [3:0] AN,
    output logic [7:0] SEGMENT,
    output logic [7:0] best,
    output logic       bcd_valid
);

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    localparam logic [SCAN_BITS-1:0] CNT_ONE = {{(SCAN_BITS-1){1'b0}}, 1'b1};

    conv_state_t conv_state, conv_next;

    logic [7:0]  src;
    logic [7:0]  src_q;
    logic [19:0] shreg;        // {hundreds, tens, ones, binary}
    logic [19:0] shreg_adj;
    logic [2:0]  bit_cnt;
    logic [3:0]  hund, tens, ones;
    logic        isdead_q;
    logic        do_load, do_shift, do_finish;

    logic [SCAN_BITS-1:0] cnt, cnt_next;
    logic [1:0]           sel_next;
    logic [3:0]           an_next;
    logic [7:0]           seg_next;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h90;
            default: glyph = 8'hFF;
        endcase
    endfunction

    // While dead the display shows the best score instead of the live one.
    assign src = (state == 2'b10) ? best : score;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) conv_state <= CONV_IDLE;
        else       conv_state <= conv_next;
    end

    always_comb begin
        conv_next = conv_state;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_finish = 1'b0;
        case (conv_state)
            CONV_IDLE: begin
                if (src != src_q) begin
                    conv_next = CONV_SHIFT;
                    do_load   = 1'b1;
                end
            end
            CONV_SHIFT: begin
                do_shift = 1'b1;
                if (bit_cnt == 3'd7) conv_next = CONV_DONE;
            end
            CONV_DONE: begin
                do_finish = 1'b1;
                conv_next = CONV_IDLE;
            end
            default: conv_next = CONV_IDLE;
        endcase
    end

    // Add-3 correction applied to every BCD nibble before the shift.
    always_comb begin
        shreg_adj = shreg;
        if (shreg[19:16] >= 4'd5) shreg_adj[19:16] = shreg[19:16] + 4'd3;
        if (shreg[15:12] >= 4'd5) shreg_adj[15:12] = shreg[15:12] + 4'd3;
        if (shreg[11:8]  >= 4'd5) shreg_adj[11:8]  = shreg[11:8]  + 4'd3;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            src_q     <= 8'd0;
            shreg     <= 20'd0;
            bit_cnt   <= 3'd0;
            hund      <= 4'd0;
            tens      <= 4'd0;
            ones      <= 4'd0;
            bcd_valid <= 1'b1;
        end else begin
            if (do_load) begin
                src_q     <= src;
                shreg     <= {12'd0, src};
                bit_cnt   <= 3'd0;
                bcd_valid <= 1'b0;
            end
            if (do_shift) begin
                shreg   <= {shreg_adj[18:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
            // Display digits only move on completion, never mid-conversion.
            // If the source moved while busy, valid stays low; IDLE restarts.
            if (do_finish) begin
                hund      <= shreg[19:16];
                tens      <= shreg[15:12];
                ones      <= shreg[11:8];
                bcd_valid <= (src == src_q);
            end
        end
    end

    // ---------------- best score ----------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            isdead_q <= 1'b0;
            best     <= 8'd0;
        end else begin
            isdead_q <= isDead;
            if (isDead && !isdead_q && (score > best)) best <= score;
        end
    end

    // ---------------- display scan ----------------
    // AN/SEGMENT are computed from the next counter value so the registered
    // outputs always agree with the counter's current digit select.
    always_comb begin
        cnt_next = cnt + CNT_ONE;
        sel_next = cnt_next[SCAN_BITS-1:SCAN_BITS-2];
        an_next  = ~(4'b0001 << sel_next);
        seg_next = 8'hFF;
        case (sel_next)
            2'd0: seg_next = glyph(ones);
            2'd1: seg_next = (hund == 4'd0 && tens == 4'd0) ? 8'hFF : glyph(tens);
            2'd2: seg_next = (hund == 4'd0) ? 8'hFF : glyph(hund);
            2'd3: begin
                if (state == 2'b01)      seg_next = 8'h8C;
                else if (state == 2'b10) seg_next = 8'h83;
                else                     seg_next = 8'hFF;
            end
            default: seg_next = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt     <= '0;
            AN      <= 4'b1110;
            SEGMENT <= 8'hC0;
        end else begin
            cnt     <= cnt_next;
            AN      <= an_next;
            SEGMENT <= seg_next;
        end
    end

endmodule

// File: doc/score_seg_driver.md
SCORE_SEG_DRIVER -- requirements
Module: score_seg_driver

Interface
REQ-001 Parameter SCAN_BITS, default 17: scan counter width; each digit is active for 2^(SCAN_BITS-2) clk cycles.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 clrn  input  1  asynchronous, active-low reset.
REQ-004 state  input  2  game state: 2'b00 idle, 2'b01 playing, 2'b10 dead, 2'b11 treated as idle.
REQ-005 score  input  8  current binary score from the pipe generator, 0..255.
REQ-006 isDead  input  1  death flag from bird control, level, asynchronous to score updates.
REQ-007 AN  output  4  digit enables, active-low; AN[0] is the rightmost digit.
REQ-008 SEGMENT  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-009 best  output  8  highest score recorded since reset, binary.
REQ-010 bcd_valid  output  1  high when the displayed BCD matches the current source value.

Function
REQ-011 Source value: best when state==2'b10, else score; held in a registered copy src_q.
REQ-012 Conversion start: when not busy and the source value differs from src_q, load src_q, clear the shift register, set busy, and drop bcd_valid.
REQ-013 Conversion method: sequential shift-add-3 (double dabble), one bit per cycle, MSB first, 8 shift cycles.
REQ-014 Add-3 rule: before each shift, any BCD nibble >= 5 gets 3 added.
REQ-015 Shift register width: 12-bit BCD (hundreds, tens, ones) plus 8-bit binary.
REQ-016 Latency: bcd_valid rises exactly 9 cycles after the start edge (1 load + 8 shifts).
REQ-017 Display register update: hundreds, tens and ones registers update only on conversion completion, so the display never shows partial results.
REQ-018 Source change while busy: the in-flight conversion completes; the next idle cycle detects the mismatch and restarts; bcd_valid stays low throughout.
REQ-019 Best update on the isDead rising edge (registered edge detect): best <= score if score > best; equal or lower scores leave best unchanged.
REQ-020 isDead held high does not retrigger the best update; only a 0->1 transition does.
REQ-021 Scan counter: SCAN_BITS wide, free-running, wraps to 0.
REQ-022 Digit select: sel = counter[SCAN_BITS-1:SCAN_BITS-2]; sel==k drives AN = ~(1<<k).
REQ-023 Digit 0 shows ones; digit 1 shows tens; digit 2 shows hundreds.
REQ-024 Digit 3 shows a mode glyph: 'P' (8'h8C) when playing, 'b' (8'h83) when dead, blank (8'hFF) when idle.
REQ-025 Leading-zero blanking: hundreds blank when 0; tens blank when hundreds==0 and tens==0; ones always shown.
REQ-026 Glyphs 0-9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90; dp always off.
REQ-027 AN and SEGMENT are registered, change together, and remain mutually consistent.

Reset
REQ-028 When clrn is low: counter, src_q, shift register, BCD digit registers, best and edge-detect register are cleared, and busy=0.
REQ-029 Reset output values: bcd_valid=1 (0 matches 0), AN=4'b1110, SEGMENT=8'hC0.
REQ-030 Reset asserted mid-conversion aborts the conversion with no partial result retained; after release, normal operation resumes from the reset state.

Verification
REQ-031 Scenario: state=01, score 0->137 -> bcd_valid low for 9 cycles, then digits 1/3/7; digit 3 shows 8'h8C.
REQ-032 Scenario: score=5 -> hundreds and tens blank (8'hFF), ones 8'h92; score=255 -> 8'hA4, 8'h92, 8'h92.
REQ-033 Scenario: score steps 10->11 on cycle 3 of a conversion -> display shows 10 after 9 cycles, then 11 9 cycles later; no intermediate value appears.
REQ-034 Scenario: isDead pulses with score 42, then 30, then 42 -> best=42 throughout; state=10 -> display shows 42 with glyph 8'h83.
REQ-035 Scenario: SCAN_BITS=4 -> AN cycles 1110, 1101, 1011, 0111 with 4 cycles per digit, then wraps.
REQ-036 Scenario: clrn pulsed low mid-conversion of 200 -> all outputs match reset values immediately, with no 200 displayed until the next conversion completes.
